inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//   Write-side counterpart of the instruction fetch path. It receives a byte stream on a
//   valid/ready handshake, assembles WIDTH-bit instruction words (high byte first) and writes
//   them into the instruction Mem through its write port, starting at address 0.
//   It holds the processor core in reset (cpu_hold) until a complete load has passed its checksum.
// PARAMETERS
//   WIDTH     16  instruction word width; fixed at 16, i.e. two bytes per word
//   I_ADDR_W  8   instruction memory address width; depth = 2**I_ADDR_W words
// PORTS
//   clk        in   1         system clock, rising edge
//   reset      in   1         asynchronous, active-low reset
//   start      in   1         begin a load; sampled in IDLE, DONE and ERROR only
//   in_valid   in   1         byte on in_data is valid
//   in_data    in   8         stream byte
//   in_ready   out  1         loader accepts a byte this cycle
//   mem_write  out  1         write strobe to instruction Mem
//   mem_addr   out  I_ADDR_W  write address
//   mem_data   out  WIDTH     write data
//   cpu_hold   out  1         1 = core held in reset; drives the core reset
//   done       out  1         load completed, checksum OK
//   error      out  1         load aborted (oversize count or bad checksum)
// BEHAVIOUR
//   Reset (reset=0, async):
//     state=IDLE; in_ready=0, mem_write=0, mem_addr=0, mem_data=0, done=0, error=0, cpu_hold=1.
//   Byte transfer: a byte is transferred only on a clk edge with in_valid && in_ready.
//     in_ready is a registered function of state: 1 only in CNT_HI, CNT_LO, D_HI, D_LO, CHK.
//   Frame format: CNT_HI, CNT_LO (16-bit word count N), then N x {D_HI, D_LO}, then 1 checksum byte.
//   Checksum: 8-bit XOR of all data bytes only; the count bytes are excluded.
//   FSM:
//     IDLE   -> CNT_HI when start. Clear done, error, chk, word index, mem_addr; set cpu_hold=1.
//     CNT_HI -> CNT_LO on a byte; count[15:8] = byte.
//     CNT_LO -> on a byte, count[7:0] = byte, then:
//               N > 2**I_ADDR_W -> ERROR; N == 0 -> CHK; otherwise -> D_HI.
//     D_HI   -> D_LO on a byte; word[15:8] = byte; chk ^= byte.
//     D_LO   -> WR on a byte; word[7:0] = byte; chk ^= byte.
//     WR     -> exactly one cycle: mem_write=1, mem_addr=index, mem_data=word; in_ready=0.
//               Increment index. Next state is CHK if index+1 == N, else D_HI.
//     CHK    -> on a byte: byte == chk -> DONE, else -> ERROR.
//     DONE   -> done=1, cpu_hold=0; hold until start, then behave as IDLE+start.
//     ERROR  -> error=1, cpu_hold=1; hold until start, then behave as IDLE+start.
//   Timing and ordering:
//     The write occurs one cycle after the low byte is accepted.
//     Minimum load time = 3N + 3 cycles with in_valid held high.
//     Gaps in in_valid stall the FSM with no side effects.
//     start is ignored in every state other than IDLE, DONE and ERROR.
//   Address range: index and mem_addr are I_ADDR_W+1 bits internally; mem_addr outputs the low
//     I_ADDR_W bits. N = 2**I_ADDR_W is legal (last write to the max address); no wrap to 0 occurs.
//   Failed loads: words written before an ERROR remain in Mem. cpu_hold keeps the core from running them.
//   Reset mid-load: asynchronous return to the reset values above. A partial frame is discarded,
//     and the next load requires start.
//   Outputs done, error and cpu_hold are registered. done and error are never 1 together.
// TESTING
//   1. start; bytes 00 03 12 34 AB CD 00 01 41 -> writes (0,1234),(1,ABCD),(2,0001); done=1; cpu_hold=0.
//   2. Same frame with checksum byte 42 -> 3 writes occur; error=1; done=0; cpu_hold stays 1.
//   3. Bytes 00 00 00 (N=0, checksum 00) -> no mem_write pulses; done=1.
//   4. I_ADDR_W=8, count bytes 01 01 (N=257) -> error=1 right after CNT_LO; no writes; in_ready=0.
//   5. N=2 with in_valid toggling randomly -> identical writes; the cycle after each D_LO accept has
//      in_ready=0 and mem_write=1.
//   6. Assert reset mid D_LO -> outputs at reset values immediately; then start and test 1 again -> passes.

Source files
------------

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader : byte-stream loader for the instruction memory; holds the
// core in reset until a load passes its XOR checksum.   Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_mem_loader #(
  parameter int WIDTH    = 16,
  parameter int I_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_write,
  output logic [I_ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CNT_HI = 4'd1,
    S_CNT_LO = 4'd2,
    S_D_HI   = 4'd3,
    S_D_LO   = 4'd4,
    S_WR     = 4'd5,
    S_CHK    = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  localparam logic [16:0] c_max_words = 17'(2 ** I_ADDR_W);

  state_t              r_state;
  logic [15:0]         r_count;
  logic [I_ADDR_W:0]   r_idx;
  logic [7:0]          r_chk;
  logic [7:0]          r_hi;

  logic                w_xfer;
  logic [15:0]         w_count;
  logic                w_oversize;
  logic [I_ADDR_W:0]   w_idx_inc;
  logic                w_last;

  assign w_xfer     = in_valid && in_ready;
  assign w_count    = {r_count[15:8], in_data};
  assign w_oversize = ({1'b0, w_count} > c_max_words);
  assign w_idx_inc  = r_idx + 1'b1;
  // Index is one bit wider than the address so N = 2**I_ADDR_W terminates without wrapping.
  assign w_last     = (16'(w_idx_inc) == r_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b1;
      r_count   <= '0;
      r_idx     <= '0;
      r_chk     <= '0;
      r_hi      <= '0;
    end else begin
      mem_write <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state  <= S_CNT_HI;
            in_ready <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            r_chk    <= '0;
            r_idx    <= '0;
            mem_addr <= '0;
          end
        end
        S_CNT_HI: begin
          if (w_xfer) begin
            r_count[15:8] <= in_data;
            r_state       <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= in_data;
            if (w_oversize) begin
              r_state  <= S_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end else if (w_count == 16'd0) begin
              r_state <= S_CHK;
            end else begin
              r_state <= S_D_HI;
            end
          end
        end
        S_D_HI: begin
          if (w_xfer) begin
            r_hi    <= in_data;
            r_chk   <= r_chk ^ in_data;
            r_state <= S_D_LO;
          end
        end
        S_D_LO: begin
          if (w_xfer) begin
            mem_write <= 1'b1;
            mem_addr  <= r_idx[I_ADDR_W-1:0];
            mem_data  <= {r_hi, in_data};
            r_chk     <= r_chk ^ in_data;
            in_ready  <= 1'b0;
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          r_idx    <= w_idx_inc;
          in_ready <= 1'b1;
          r_state  <= w_last ? S_CHK : S_D_HI;
        end
        S_CHK: begin
          if (w_xfer) begin
            in_ready <= 1'b0;
            if (in_data == r_chk) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state  <= S_ERROR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader : directed self-checking bench for inst_mem_loader.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_mem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int tests;
  int fails;
  int cyc;
  int wr_n;
  logic [7:0]  wa [0:511];
  logic [15:0] wd [0:511];
  logic [7:0]  fr [0:31];

  inst_mem_loader #(.WIDTH(16), .I_ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (wr_n < 512) begin
        wa[wr_n] = mem_addr;
        wd[wr_n] = mem_data;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one byte, optionally after an idle gap, and returns #1 after it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit lo_byte);
    int waitc;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    waitc = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waitc++;
      if (waitc > 50) begin
        tests++; fails++;
        $display("FAIL handshake_timeout: in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (lo_byte) begin
      tests++;
      if ({in_ready, mem_write} !== 2'b01) begin
        fails++;
        $display("FAIL wr_cycle: in_ready,mem_write=%b required 01", {in_ready, mem_write});
      end
    end
  endtask

  // Sends fr[0..len-1]; bytes at odd positions 3,5,... are low data bytes.
  task automatic send_frame(input int len, input int nwords, input bit gaps);
    for (int i = 0; i < len; i++) begin
      send_byte(fr[i], gaps ? int'($urandom_range(0, 3)) : 0,
                (i >= 3) && (i < 2 + 2 * nwords) && (i % 2 == 1));
    end
  endtask

  task automatic check_flags(input string name, input logic d, input logic e, input logic h);
    tests++;
    if ({done, error, cpu_hold} !== {d, e, h}) begin
      fails++;
      $display("FAIL %s_flags: done,error,hold=%b required %b", name,
               {done, error, cpu_hold}, {d, e, h});
    end
  endtask

  task automatic check_basic_writes(input string name);
    tests++;
    if (wr_n !== 3) begin
      fails++;
      $display("FAIL %s_wr_count: got %0d required 3", name, wr_n);
    end else begin
      tests++;
      if (wa[0] !== 8'd0 || wd[0] !== 16'h1234 || wa[1] !== 8'd1 || wd[1] !== 16'hABCD ||
          wa[2] !== 8'd2 || wd[2] !== 16'h0001) begin
        fails++;
        $display("FAIL %s_wr_data: got (%h,%h)(%h,%h)(%h,%h) required (00,1234)(01,abcd)(02,0001)",
                 name, wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
      end
    end
  endtask

  task automatic load_basic(input logic [7:0] chk);
    fr[0] = 8'h00; fr[1] = 8'h03; fr[2] = 8'h12; fr[3] = 8'h34; fr[4] = 8'hAB;
    fr[5] = 8'hCD; fr[6] = 8'h00; fr[7] = 8'h01; fr[8] = chk;
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, mem_write, mem_addr, mem_data, done, error, cpu_hold} !== {2'b00, 8'h00, 16'h0000, 3'b001}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b wr=%b addr=%h data=%h done=%b err=%b hold=%b required 0 0 00 0000 0 0 1",
               in_ready, mem_write, mem_addr, mem_data, done, error, cpu_hold);
    end
  endtask

  task automatic test_basic_load();
    int c0;
    wr_n = 0;
    load_basic(8'h41);
    pulse_start();
    c0 = cyc;
    send_frame(9, 3, 1'b0);
    check_flags("basic", 1'b1, 1'b0, 1'b0);
    check_basic_writes("basic");
    tests++;
    if (cyc - c0 !== 12) begin
      fails++;
      $display("FAIL basic_load_time: got %0d cycles required 12", cyc - c0);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_ready_after: got %b required 0", in_ready);
    end
  endtask

  task automatic test_bad_checksum();
    wr_n = 0;
    load_basic(8'h42);
    pulse_start();
    check_flags("bad_start", 1'b0, 1'b0, 1'b1);
    send_frame(9, 3, 1'b0);
    check_flags("bad", 1'b0, 1'b1, 1'b1);
    check_basic_writes("bad");
  endtask

  task automatic test_zero_count();
    wr_n = 0;
    fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = 8'h00;
    pulse_start();
    send_frame(3, 0, 1'b0);
    repeat (2) @(posedge clk); #1;
    check_flags("zero", 1'b1, 1'b0, 1'b0);
    tests++;
    if (wr_n !== 0) begin
      fails++;
      $display("FAIL zero_wr_count: got %0d required 0", wr_n);
    end
  endtask

  task automatic test_oversize();
    wr_n = 0;
    fr[0] = 8'h01; fr[1] = 8'h01;
    pulse_start();
    send_frame(2, 0, 1'b0);
    check_flags("oversize", 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    tests++;
    if (wr_n !== 0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL oversize_quiet: writes=%0d rdy=%b required 0 0", wr_n, in_ready);
    end
  endtask

  task automatic test_max_count();
    int cw;
    wr_n = 0;
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 0, 1'b0);
      send_byte(~8'(i), 0, 1'b1);
    end
    send_byte(8'h00, 0, 1'b0);
    check_flags("max", 1'b1, 1'b0, 1'b0);
    tests++;
    if (wr_n !== 256) begin
      fails++;
      $display("FAIL max_wr_count: got %0d required 256", wr_n);
    end
    cw = 0;
    for (int i = 0; i < 256 && i < wr_n; i++)
      if (wa[i] !== 8'(i) || wd[i] !== {8'(i), ~8'(i)}) cw++;
    tests++;
    if (cw !== 0) begin
      fails++;
      $display("FAIL max_wr_data: %0d bad writes, last (%h,%h) required (ff,ff00)", cw, wa[255], wd[255]);
    end
  endtask

  task automatic test_stall();
    wr_n = 0;
    fr[0] = 8'h00; fr[1] = 8'h02; fr[2] = 8'hDE; fr[3] = 8'hAD;
    fr[4] = 8'hBE; fr[5] = 8'hEF; fr[6] = 8'h22;
    pulse_start();
    send_frame(7, 2, 1'b1);
    check_flags("stall", 1'b1, 1'b0, 1'b0);
    tests++;
    if (wr_n !== 2 || wa[0] !== 8'd0 || wd[0] !== 16'hDEAD || wa[1] !== 8'd1 || wd[1] !== 16'hBEEF) begin
      fails++;
      $display("FAIL stall_writes: n=%0d (%h,%h)(%h,%h) required 2 (00,dead)(01,beef)",
               wr_n, wa[0], wd[0], wa[1], wd[1]);
    end
  endtask

  task automatic test_reset_mid();
    load_basic(8'h41);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(fr[i], 0, (i == 3));
    in_data  = 8'hCD;
    in_valid = 1'b1;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    test_reset();
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_load();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; wr_n = 0;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_zero_count();
    test_oversize();
    test_stall();
    test_max_count();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
